// File: rtl/cla_slice_scheduler.sv
// cla_slice_scheduler: two requesters share one SLICE-bit CLA slice.
// Each WIDTH-bit add runs LSB slice first over NSLICE cycles.
module cla_slice_scheduler #(
  parameter int SLICE = 8,
  parameter int WIDTH = 32,
  localparam int NSLICE = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_width_chk
      $error("WIDTH is not a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic             id_q;
  logic [IW-1:0]    idx;

  logic             g0;
  logic             g1;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;
  logic [SLICE-1:0] ssum;
  logic [WIDTH-1:0] res_nx;

  // Round-robin grant, only offered while idle; ties go away from last_grant.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state == IDLE) begin
      g0 = req0_valid & (~req1_valid | last_grant);
      g1 = req1_valid & (~req0_valid | ~last_grant);
    end
  end

  assign req0_ready = g0;
  assign req1_ready = g1;

  // One CLA slice pass over slice idx, merged into the partial result.
  always_comb begin
    sa = a_q[idx*SLICE +: SLICE];
    sb = b_q[idx*SLICE +: SLICE];
    p = sa ^ sb;
    g = sa & sb;
    c = '0;
    c[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    ssum = p ^ c[SLICE-1:0];
    res_nx = acc;
    res_nx[idx*SLICE +: SLICE] = ssum;
  end

  // Scheduler FSM: accept, run NSLICE passes, present result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      carry_q    <= 1'b0;
      id_q       <= 1'b0;
      idx        <= '0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (g0 | g1) begin
            a_q        <= g1 ? req1_a : req0_a;
            b_q        <= g1 ? req1_b : req0_b;
            carry_q    <= g1 ? req1_cin : req0_cin;
            id_q       <= g1;
            last_grant <= g1;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          acc     <= res_nx;
          carry_q <= c[SLICE];
          idx     <= idx + 1'b1;
          if (idx == LAST) begin
            rsp_sum   <= res_nx;
            rsp_cout  <= c[SLICE];
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_slice_scheduler.sv
// tb_cla_slice_scheduler: directed vectors plus a
// scoreboarded random sweep for cla_slice_scheduler.
module tb_cla_slice_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_cin;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cla_slice_scheduler #(.SLICE(8), .WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the handshake edge.
  task automatic issue(input bit which, input logic [31:0] a,
                       input logic [31:0] b, input logic cin);
    bit seen = 0;
    if (which) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1;
    end
    #1;
    for (int n = 0; n < 20 && !seen; n++) begin
      if ((which ? req1_ready : req0_ready) === 1'b1) seen = 1;
      else tick();
    end
    chk("issue_ready", 64'(seen), 64'd1);
    tick();
    req0_valid = 0;
    req1_valid = 0;
  endtask

  // Count edges from the handshake until rsp_valid rises.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      lat++;
      if (rsp_valid === 1'b1) break;
    end
    if (rsp_valid !== 1'b1) chk("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic take_rsp(input string tag, input logic [31:0] s,
                          input logic co, input logic id);
    chk({tag, "_rsp"}, {30'd0, rsp_id, rsp_cout, rsp_sum},
        {30'd0, id, co, s});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk({tag, "_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  int lat;
  int got_n;
  int both;
  logic [31:0] hold_sum;
  logic [33:0] exp_q[$];
  logic [33:0] e;
  int issued;
  bit h0;
  bit h1;

  initial begin
    rst = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
    rsp_ready = 0;
    tick();
    tick();
    chk("rst_out", {28'd0, req0_ready, req1_ready, rsp_valid, busy,
                    rsp_sum}, 64'd0);
    chk("rst_cid", {62'd0, rsp_cout, rsp_id}, 64'd0);
    rst = 0;
    tick();

    // Single request from req0.
    req0_a = 32'hFF; req0_b = 32'h1; req0_cin = 0; req0_valid = 1;
    #1;
    chk("t1_ready", {62'd0, req0_ready, req1_ready}, 64'b10);
    tick();
    req0_valid = 0;
    #1;
    chk("t1_busy", {62'd0, busy, req0_ready}, 64'b10);
    wait_rsp(lat);
    chk("t1_lat", 64'(lat), 64'd4);
    take_rsp("t1", 32'h100, 0, 0);
    chk("t1_idle", 64'(busy), 64'd0);

    // Full carry ripple from req1.
    issue(1, 32'hFFFF_FFFF, 32'h0, 1);
    wait_rsp(lat);
    chk("t2_lat", 64'(lat), 64'd4);
    take_rsp("t2", 32'h0, 1, 1);

    // Fairness with both requesters held valid.
    req0_a = 1; req0_b = 1; req0_cin = 0;
    req1_a = 32'h4D; req1_b = 32'h2B; req1_cin = 0;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    got_n = 0; both = 0;
    for (int n = 0; n < 60 && got_n < 4; n++) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if (rsp_valid) begin
        chk($sformatf("t3_id%0d", got_n), 64'(rsp_id), 64'(got_n % 2));
        chk($sformatf("t3_sum%0d", got_n), 64'(rsp_sum),
            (got_n % 2) ? 64'h78 : 64'h2);
        got_n++;
        if (got_n == 4) begin
          req0_valid = 0; req1_valid = 0;
        end
      end
      tick();
    end
    rsp_ready = 0;
    chk("t3_count", 64'(got_n), 64'd4);
    chk("t3_dual", 64'(both), 64'd0);

    // Backpressure in DONE.
    issue(0, 32'h1234_5678, 32'h1111_1111, 0);
    wait_rsp(lat);
    hold_sum = rsp_sum;
    chk("t4_sum", 64'(hold_sum), 64'h2345_6789);
    req0_valid = 1; req1_valid = 1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t4_hold", {26'd0, rsp_valid, busy, req0_ready, req1_ready,
                      rsp_sum}, {26'd0, 4'b1100, 32'h2345_6789});
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("t4_idle", {62'd0, rsp_valid, busy}, 64'd0);
    chk("t4_rr", {62'd0, req0_ready, req1_ready}, 64'b01);
    req0_valid = 0; req1_valid = 0;
    tick();

    // Asynchronous reset in the second RUN cycle; req0 owns last_grant.
    issue(0, 32'h5, 32'h6, 0);
    tick();
    rst = 1;
    #1;
    chk("t5_rst", {29'd0, rsp_valid, rsp_cout, busy, rsp_sum}, 64'd0);
    chk("t5_id", 64'(rsp_id), 64'd0);
    tick();
    rst = 0;
    for (int n = 0; n < 6; n++) tick();
    chk("t5_norsp", {62'd0, rsp_valid, busy}, 64'd0);
    req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF; req0_cin = 1;
    req1_a = 32'h1; req1_b = 32'h2; req1_cin = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("t5_grant", {62'd0, req0_ready, req1_ready}, 64'b10);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_rsp(lat);
    take_rsp("t5", 32'hFFFF_FFFF, 1, 0);

    // Random sweep against a reference adder.
    issued = 0; got_n = 0; both = 0;
    for (int n = 0; n < 20000 && got_n < 200; n++) begin
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (req0_ready && req1_ready) both++;
      if (h0) begin
        e = {1'b0, 33'(req0_a) + 33'(req0_b) + 33'(req0_cin)};
        exp_q.push_back(e);
      end
      if (h1) begin
        e = {1'b1, 33'(req1_a) + 33'(req1_b) + 33'(req1_cin)};
        exp_q.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra", 64'(got_n), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_rsp", {30'd0, rsp_id, rsp_cout, rsp_sum}, 64'(e));
        end
        got_n++;
      end
      tick();
      if (h0) req0_valid = 0;
      if (h1) req1_valid = 0;
      if (!req0_valid && issued < 200 && $urandom_range(0, 2) != 0) begin
        req0_a = $urandom; req0_b = $urandom;
        req0_cin = 1'($urandom_range(0, 1));
        req0_valid = 1; issued++;
      end
      if (!req1_valid && issued < 200 && $urandom_range(0, 2) != 0) begin
        req1_a = $urandom; req1_b = $urandom;
        req1_cin = 1'($urandom_range(0, 1));
        req1_valid = 1; issued++;
      end
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      #1;
    end
    rsp_ready = 0;
    chk("rnd_count", 64'(got_n), 64'd200);
    chk("rnd_left", 64'(exp_q.size()), 64'd0);
    chk("rnd_dual", 64'(both), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_slice_scheduler.md
Name: cla_slice_scheduler

Overview:
- Shares one SLICE-bit carry look-ahead adder slice between two requesters using round-robin arbitration.
- Each granted request is a WIDTH-bit add, executed as WIDTH/SLICE passes through the slice, LSB slice first, with the carry-out of each pass chained into the next.
- Sits between the two operand producers and a single result consumer.
- Valid/ready handshake on every interface.

Parameters:
- SLICE, 8, slice width in bits. The internal slice uses the team's CLA equations: P=A^B, G=A&B, C[i+1]=G[i]|(P[i]&C[i]), sum=P^C[SLICE-1:0].
- WIDTH, 32, operand width in bits. Must be an integer multiple of SLICE, checked at elaboration.
- NSLICE, WIDTH/SLICE, derived: number of passes per add. Not to be overridden.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand set
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req0_cin  in  1  carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  WIDTH  A+B+cin, modulo 2^WIDTH
- rsp_cout  out  1  carry-out of the top slice
- rsp_id  out  1  requester that issued this result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, last_grant=1 (so requester 0 wins first)
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0
  - slice index=0, carry register=0, operand registers=0
  - Reset during RUN or DONE discards the in-flight add; no response is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready is combinational and asserts only in IDLE, for at most one requester per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - On a handshake edge: latch A, B, cin and id; set last_grant=id; slice index=0; go to RUN.
- RUN:
  - Each cycle adds slice k = operand bits [k*SLICE +: SLICE] plus the carry register.
  - Writes the SLICE sum bits into the result register at slice k.
  - Carry register takes the slice carry-out. Slice 0 uses the latched cin.
  - After slice NSLICE-1: rsp_cout = final carry, go to DONE.
  - Exactly NSLICE cycles in RUN.
- DONE:
  - rsp_valid=1. rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready.
  - On an rsp_valid & rsp_ready edge: go to IDLE, rsp_valid=0.
  - No request is accepted in that same cycle, giving a one-cycle bubble.
- Latency: handshake on edge t → rsp_valid high after edge t+NSLICE. Throughput is one add per NSLICE+2 cycles with rsp_ready held high.
- Fairness: with both requesters held valid, grants strictly alternate 0,1,0,1…
- Input changes while not in IDLE are ignored. A requester's valid may stay high across an add.
- rsp_sum, rsp_cout and rsp_id are undefined-free: they hold the last result (0 after reset) while rsp_valid=0.

Test Plan:
- Single request, req0 a=0x000000FF b=0x00000001 cin=0 → req0_ready pulse; rsp_valid 4 cycles after handshake; rsp_sum=0x00000100, rsp_cout=0, rsp_id=0.
- Full carry ripple, req1 a=0xFFFFFFFF b=0x00000000 cin=1 → rsp_sum=0x00000000, rsp_cout=1, rsp_id=1.
- Both requesters held valid for 4 adds (req0 a=1 b=1 cin=0; req1 a=0x4D b=0x2B cin=0) → rsp_id sequence 0,1,0,1; sums 0x2, 0x78, 0x2, 0x78; never two readys in one cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_valid and data stable, both reqN_ready=0, busy=1; result accepted on first rsp_ready=1; IDLE one cycle later.
- Reset asserted asynchronously in the second RUN cycle → all outputs 0 immediately. After release, req0 a=0xFFFFFFFF b=0xFFFFFFFF cin=1 → rsp_sum=0xFFFFFFFF, rsp_cout=1, rsp_id=0 (last_grant reset honoured).
- Randomised sweep of 200 adds against a reference A+B+cin, with random valid/ready gaps → all sums, carries and ids match; no lost or duplicated responses.
